// File: rtl/gpio_irq_pkg.sv
// Shared register map and defaults for the GPIO input / interrupt controller.
package gpio_irq_pkg;
  localparam int GPIO_IRQ_RAW      = 0;
  localparam int GPIO_IRQ_STATE    = 1;
  localparam int GPIO_IRQ_RISE_EN  = 2;
  localparam int GPIO_IRQ_FALL_EN  = 3;
  localparam int GPIO_IRQ_PENDING  = 4;
  localparam int GPIO_IRQ_IRQ_EN   = 5;
  localparam int GPIO_IRQ_SOFT_SET = 6;

  // 1 ms of stability at a 12 MHz core clock
  localparam int GPIO_IRQ_DEBOUNCE_CYCLES = 12000;
endpackage

// File: rtl/gpio_debounce.sv
// One input pin: 2-flop synchroniser, debounce counter and accepted STATE.
// STATE moves on the DEBOUNCE_CYCLES-th consecutive disagreeing edge; rise/fall pulse on that edge.
module gpio_debounce
  import gpio_irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = GPIO_IRQ_DEBOUNCE_CYCLES,
  parameter int CNT_BITS        = 14
) (
  input  logic CLK,
  input  logic RSTb,
  input  logic i_pin,
  output logic o_raw,
  output logic o_state,
  output logic o_rise,
  output logic o_fall
);
  localparam logic [CNT_BITS-1:0] LP_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic                r_sync1;
  logic                r_raw;
  logic                r_state;
  logic [CNT_BITS-1:0] r_cnt;
  logic                w_diff;
  logic                w_take;

  assign w_diff = r_raw != r_state;
  assign w_take = w_diff && (r_cnt == LP_LAST);

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_sync1 <= 1'b0;
      r_raw   <= 1'b0;
      r_state <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_raw   <= r_sync1;
      // any return to the accepted level restarts the count
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_take) begin
        r_cnt   <= '0;
        r_state <= r_raw;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_raw   = r_raw;
  assign o_state = r_state;
  assign o_rise  = w_take & r_raw;
  assign o_fall  = w_take & ~r_raw;
endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO input controller: debounced pins, edge-latched pending bits, registered level IRQ.
// Register writes land on the WR edge; DATA_OUT is a combinational read of ADDRESS.
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter int BITS            = 16,
  parameter int ADDRESS_BITS    = 4,
  parameter int NPINS           = 6,
  parameter int DEBOUNCE_CYCLES = GPIO_IRQ_DEBOUNCE_CYCLES,
  parameter int CNT_BITS        = 14
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic [ADDRESS_BITS-1:0] ADDRESS,
  input  logic [BITS-1:0]         DATA_IN,
  output logic [BITS-1:0]         DATA_OUT,
  input  logic                    WR,
  input  logic [NPINS-1:0]        INPUT_PINS,
  output logic                    IRQ
);
  localparam logic [ADDRESS_BITS-1:0] A_RAW      = ADDRESS_BITS'(GPIO_IRQ_RAW);
  localparam logic [ADDRESS_BITS-1:0] A_STATE    = ADDRESS_BITS'(GPIO_IRQ_STATE);
  localparam logic [ADDRESS_BITS-1:0] A_RISE_EN  = ADDRESS_BITS'(GPIO_IRQ_RISE_EN);
  localparam logic [ADDRESS_BITS-1:0] A_FALL_EN  = ADDRESS_BITS'(GPIO_IRQ_FALL_EN);
  localparam logic [ADDRESS_BITS-1:0] A_PENDING  = ADDRESS_BITS'(GPIO_IRQ_PENDING);
  localparam logic [ADDRESS_BITS-1:0] A_IRQ_EN   = ADDRESS_BITS'(GPIO_IRQ_IRQ_EN);
  localparam logic [ADDRESS_BITS-1:0] A_SOFT_SET = ADDRESS_BITS'(GPIO_IRQ_SOFT_SET);

  logic [NPINS-1:0] w_raw;
  logic [NPINS-1:0] w_state;
  logic [NPINS-1:0] w_rise;
  logic [NPINS-1:0] w_fall;
  logic [NPINS-1:0] w_wdat;
  logic [NPINS-1:0] w_set;
  logic [NPINS-1:0] w_clr;
  logic [NPINS-1:0] r_rise_en;
  logic [NPINS-1:0] r_fall_en;
  logic [NPINS-1:0] r_pending;
  logic [NPINS-1:0] r_irq_en;
  logic             r_irq;

  genvar g;
  generate
    for (g = 0; g < NPINS; g++) begin : g_pin
      gpio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_BITS       (CNT_BITS)
      ) u_deb (
        .CLK    (CLK),
        .RSTb   (RSTb),
        .i_pin  (INPUT_PINS[g]),
        .o_raw  (w_raw[g]),
        .o_state(w_state[g]),
        .o_rise (w_rise[g]),
        .o_fall (w_fall[g])
      );
    end
    if (NPINS < BITS) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = ^DATA_IN[BITS-1:NPINS];
    end
  endgenerate

  assign w_wdat = DATA_IN[NPINS-1:0];
  assign w_clr  = (WR && (ADDRESS == A_PENDING)) ? w_wdat : '0;
  // OR-ing set after the clear mask lets a same-cycle set beat W1C
  assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en)
                | ((WR && (ADDRESS == A_SOFT_SET)) ? w_wdat : '0);

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_pending <= '0;
      r_irq_en  <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (WR && (ADDRESS == A_RISE_EN)) r_rise_en <= w_wdat;
      if (WR && (ADDRESS == A_FALL_EN)) r_fall_en <= w_wdat;
      if (WR && (ADDRESS == A_IRQ_EN))  r_irq_en  <= w_wdat;
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_irq     <= |(r_pending & r_irq_en);
    end
  end

  always_comb begin
    DATA_OUT = '0;
    case (ADDRESS)
      A_RAW:     DATA_OUT[NPINS-1:0] = w_raw;
      A_STATE:   DATA_OUT[NPINS-1:0] = w_state;
      A_RISE_EN: DATA_OUT[NPINS-1:0] = r_rise_en;
      A_FALL_EN: DATA_OUT[NPINS-1:0] = r_fall_en;
      A_PENDING: DATA_OUT[NPINS-1:0] = r_pending;
      A_IRQ_EN:  DATA_OUT[NPINS-1:0] = r_irq_en;
      default:   DATA_OUT = '0;
    endcase
  end

  assign IRQ = r_irq;
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Bench for gpio_irq_ctrl: a DEBOUNCE_CYCLES=8 and a DEBOUNCE_CYCLES=1 instance share all inputs.
module tb_gpio_irq_ctrl;
  localparam int BITS = 16;
  localparam int AB   = 4;
  localparam int NP   = 6;

  logic            CLK = 1'b0;
  logic            RSTb = 1'b0;
  logic [AB-1:0]   ADDRESS = '0;
  logic [BITS-1:0] DATA_IN = '0;
  logic            WR = 1'b0;
  logic [NP-1:0]   pins = '0;
  logic [BITS-1:0] dout0, dout1;
  logic            irq0, irq1;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  gpio_irq_ctrl #(.BITS(BITS), .ADDRESS_BITS(AB), .NPINS(NP), .DEBOUNCE_CYCLES(8), .CNT_BITS(4)) dut (
    .CLK(CLK), .RSTb(RSTb), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN), .DATA_OUT(dout0),
    .WR(WR), .INPUT_PINS(pins), .IRQ(irq0));

  gpio_irq_ctrl #(.BITS(BITS), .ADDRESS_BITS(AB), .NPINS(NP), .DEBOUNCE_CYCLES(1), .CNT_BITS(2)) dut1 (
    .CLK(CLK), .RSTb(RSTb), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN), .DATA_OUT(dout1),
    .WR(WR), .INPUT_PINS(pins), .IRQ(irq1));

  // Reference model: pins seen two edges late, a level is accepted after N consecutive
  // disagreeing edges, pending = (pending minus W1C) plus events/soft sets.
  logic [NP-1:0] m_p1[2], m_raw[2], m_state[2], m_pend[2];
  logic [NP-1:0] m_rise_en, m_fall_en, m_irq_en;
  logic          m_irq[2];
  int            m_run[2][NP];

  task automatic model_edge();
    logic [NP-1:0] wd, ev, clr, sset;
    int dc;
    wd = DATA_IN[NP-1:0];
    if (!RSTb) begin
      for (int k = 0; k < 2; k++) begin
        m_p1[k] = '0; m_raw[k] = '0; m_state[k] = '0; m_pend[k] = '0; m_irq[k] = 1'b0;
        for (int i = 0; i < NP; i++) m_run[k][i] = 0;
      end
      m_rise_en = '0; m_fall_en = '0; m_irq_en = '0;
      return;
    end
    clr  = (WR && ADDRESS == 4) ? wd : '0;
    sset = (WR && ADDRESS == 6) ? wd : '0;
    for (int k = 0; k < 2; k++) begin
      dc = (k == 0) ? 8 : 1;
      ev = '0;
      for (int i = 0; i < NP; i++) begin
        if (m_raw[k][i] != m_state[k][i]) begin
          m_run[k][i]++;
          if (m_run[k][i] == dc) begin
            m_state[k][i] = m_raw[k][i];
            m_run[k][i]   = 0;
            ev[i] = m_raw[k][i] ? m_rise_en[i] : m_fall_en[i];
          end
        end else begin
          m_run[k][i] = 0;
        end
      end
      m_irq[k]  = |(m_pend[k] & m_irq_en);
      m_pend[k] = (m_pend[k] & ~clr) | ev | sset;
      m_raw[k]  = m_p1[k];
      m_p1[k]   = pins;
    end
    if (WR) begin
      case (ADDRESS)
        4'd2: m_rise_en = wd;
        4'd3: m_fall_en = wd;
        4'd5: m_irq_en  = wd;
        default: ;
      endcase
    end
  endtask

  function automatic logic [BITS-1:0] mread(int k, int a);
    logic [BITS-1:0] r;
    r = '0;
    case (a)
      0: r[NP-1:0] = m_raw[k];
      1: r[NP-1:0] = m_state[k];
      2: r[NP-1:0] = m_rise_en;
      3: r[NP-1:0] = m_fall_en;
      4: r[NP-1:0] = m_pend[k];
      5: r[NP-1:0] = m_irq_en;
      default: ;
    endcase
    return r;
  endfunction

  task automatic cycle(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
    end
  endtask

  task automatic wr_reg(input logic [AB-1:0] a, input logic [BITS-1:0] d);
    ADDRESS = a; DATA_IN = d; WR = 1'b1;
    cycle();
    WR = 1'b0; DATA_IN = '0;
  endtask

  task automatic rd(input logic [AB-1:0] a, output logic [BITS-1:0] r0, output logic [BITS-1:0] r1);
    ADDRESS = a;
    #1;
    r0 = dout0;
    r1 = dout1;
  endtask

  task automatic test_reset();
    logic [BITS-1:0] r0, r1;
    RSTb = 1'b0; pins = '1;
    cycle(3);
    for (int a = 0; a < 8; a++) begin
      rd(4'(a), r0, r1);
      checks++;
      if (r0 !== 16'h0000 || r1 !== 16'h0000) begin
        errors++; $display("FAIL reset_read addr %0d: got %h/%h want 0000", a, r0, r1);
      end
    end
    checks++;
    if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b/%b want 0", irq0, irq1);
    end
    pins = '0; RSTb = 1'b1;
    cycle(4);
    pins[0] = 1'b1;
    cycle(6);
    RSTb = 1'b0;
    cycle(1);
    RSTb = 1'b1;
    rd(1, r0, r1);
    checks++;
    if (r0 !== 16'h0000) begin errors++; $display("FAIL midcount_reset_state: got %h want 0000", r0); end
    cycle(7);
    rd(1, r0, r1);
    checks++;
    if (r0 !== 16'h0000) begin errors++; $display("FAIL midcount_restart_early: got %h want 0000", r0); end
    cycle(3);
    rd(1, r0, r1);
    checks++;
    if (r0 !== 16'h0001) begin errors++; $display("FAIL midcount_restart_done: got %h want 0001", r0); end
    pins = '0;
    cycle(12);
  endtask

  task automatic test_rise();
    logic [BITS-1:0] r0, r1;
    wr_reg(2, 16'h0001);
    wr_reg(5, 16'h0001);
    pins[0] = 1'b1;
    cycle(1);
    rd(0, r0, r1);
    checks++;
    if (r0 !== 16'h0000) begin errors++; $display("FAIL rise_raw_1cyc: got %h want 0000", r0); end
    cycle(1);
    rd(0, r0, r1);
    checks++;
    if (r0 !== 16'h0001) begin errors++; $display("FAIL rise_raw_2cyc: got %h want 0001", r0); end
    cycle(7);
    rd(1, r0, r1);
    checks++;
    if (r0 !== 16'h0000) begin errors++; $display("FAIL rise_state_early: got %h want 0000", r0); end
    cycle(1);
    rd(1, r0, r1);
    checks++;
    if (r0 !== 16'h0001) begin errors++; $display("FAIL rise_state: got %h want 0001", r0); end
    rd(4, r0, r1);
    checks++;
    if (r0 !== 16'h0001 || irq0 !== 1'b0) begin
      errors++; $display("FAIL rise_pending: got %h irq %b want 0001 irq 0", r0, irq0);
    end
    cycle(1);
    checks++;
    if (irq0 !== 1'b1) begin errors++; $display("FAIL rise_irq: got %b want 1", irq0); end
  endtask

  task automatic test_glitch();
    logic [BITS-1:0] r0, r1;
    wr_reg(2, 16'h0003);
    pins[1] = 1'b1; cycle(5);
    pins[1] = 1'b0; cycle(1);
    pins[1] = 1'b1;
    cycle(9);
    rd(1, r0, r1);
    checks++;
    if (r0 !== 16'h0001) begin errors++; $display("FAIL glitch_state_early: got %h want 0001", r0); end
    cycle(1);
    rd(1, r0, r1);
    checks++;
    if (r0 !== 16'h0003) begin errors++; $display("FAIL glitch_state: got %h want 0003", r0); end
    rd(4, r0, r1);
    checks++;
    if (r0 !== 16'h0003) begin errors++; $display("FAIL glitch_pending: got %h want 0003", r0); end
  endtask

  task automatic test_w1c();
    logic [BITS-1:0] r0, r1;
    wr_reg(4, 16'h0001);
    rd(4, r0, r1);
    checks++;
    if (r0 !== 16'h0002) begin errors++; $display("FAIL w1c_clear: got %h want 0002", r0); end
    pins[1] = 1'b0;
    cycle(12);
    pins[1] = 1'b1;
    cycle(9);
    wr_reg(4, 16'h0002);
    rd(4, r0, r1);
    checks++;
    if (r0 !== 16'h0002) begin errors++; $display("FAIL set_beats_w1c: got %h want 0002", r0); end
    rd(1, r0, r1);
    checks++;
    if (r0 !== 16'h0003) begin errors++; $display("FAIL set_beats_w1c_state: got %h want 0003", r0); end
  endtask

  task automatic test_fall_irq();
    logic [BITS-1:0] r0, r1;
    wr_reg(2, 16'h0000);
    wr_reg(5, 16'h0000);
    wr_reg(3, 16'h0020);
    wr_reg(4, 16'h003F);
    pins[5] = 1'b1;
    cycle(12);
    rd(4, r0, r1);
    checks++;
    if (r0 !== 16'h0000) begin errors++; $display("FAIL fall_no_rise_pend: got %h want 0000", r0); end
    pins[5] = 1'b0;
    cycle(10);
    rd(4, r0, r1);
    checks++;
    if (r0 !== 16'h0020) begin errors++; $display("FAIL fall_pending: got %h want 0020", r0); end
    cycle(2);
    checks++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL fall_irq_masked: got %b want 0", irq0); end
    wr_reg(5, 16'h0020);
    checks++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_en_same_edge: got %b want 0", irq0); end
    cycle(1);
    checks++;
    if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_en_next: got %b want 1", irq0); end
    wr_reg(6, 16'h0004);
    rd(4, r0, r1);
    checks++;
    if (r0 !== 16'h0024) begin errors++; $display("FAIL soft_set: got %h want 0024", r0); end
    rd(6, r0, r1);
    checks++;
    if (r0 !== 16'h0000) begin errors++; $display("FAIL soft_set_reads0: got %h want 0000", r0); end
    wr_reg(4, 16'h0024);
    checks++;
    if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_hold_after_clr: got %b want 1", irq0); end
    cycle(1);
    checks++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_deassert: got %b want 0", irq0); end
  endtask

  task automatic test_fast();
    logic [BITS-1:0] r0, r1;
    logic [NP-1:0]   prev_raw, prev_state;
    wr_reg(2, 16'h003F);
    wr_reg(3, 16'h003F);
    prev_raw   = m_raw[1];
    prev_state = m_state[1];
    for (int c = 0; c < 24; c++) begin
      if (c % 2 == 0) pins[3:2] = ~pins[3:2];
      wr_reg(4, 16'h003F);
      rd(1, r0, r1);
      checks++;
      if (r1 !== {10'b0, prev_raw}) begin
        errors++; $display("FAIL fast_state_lag c%0d: got %h want %h", c, r1, {10'b0, prev_raw});
      end
      rd(4, r0, r1);
      checks++;
      if (r1 !== {10'b0, prev_raw ^ prev_state}) begin
        errors++; $display("FAIL fast_pending c%0d: got %h want %h", c, r1, {10'b0, prev_raw ^ prev_state});
      end
      prev_state = prev_raw;
      prev_raw   = m_raw[1];
    end
  endtask

  task automatic test_random();
    logic [BITS-1:0] r0, r1;
    int a;
    for (int c = 0; c < 800; c++) begin
      a = $urandom_range(0, 7);
      rd(4'(a), r0, r1);
      checks++;
      if (r0 !== mread(0, a) || r1 !== mread(1, a)) begin
        errors++;
        $display("FAIL rand_read c%0d addr %0d: got %h/%h want %h/%h", c, a, r0, r1, mread(0, a), mread(1, a));
      end
      checks++;
      if (irq0 !== m_irq[0] || irq1 !== m_irq[1]) begin
        errors++; $display("FAIL rand_irq c%0d: got %b/%b want %b/%b", c, irq0, irq1, m_irq[0], m_irq[1]);
      end
      for (int i = 0; i < NP; i++) if ($urandom_range(0, 15) == 0) pins[i] = ~pins[i];
      RSTb = (c != 400);
      if ($urandom_range(0, 3) == 0) begin
        ADDRESS = 4'($urandom_range(0, 7));
        DATA_IN = 16'($urandom);
        WR = 1'b1;
      end
      cycle();
      WR = 1'b0;
      RSTb = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_w1c();
    test_fall_irq();
    test_fast();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
